// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared states, defaults and stage names for reset_sequencer
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_SOFT_HOLD = 2'd3
  } rs_state_e;

  // Release order of the arm controller reset domains.
  typedef enum int {
    STG_BUS    = 0,
    STG_MOTION = 1,
    STG_SPI    = 2,
    STG_PWM    = 3
  } rs_stage_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_LOCK_STABLE = 1024;
  localparam int DEF_STAGE_GAP   = 16;
  localparam int DEF_SOFT_HOLD   = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the shared counter; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer with async active-high reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of an asynchronous level; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock qualified, staged reset release with soft reset
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int SOFT_HOLD   = DEF_SOFT_HOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [7:0]            lock_loss_cnt
);

  localparam int CW = cnt_width(max3(LOCK_STABLE, STAGE_GAP, SOFT_HOLD));
  localparam logic [CW-1:0]         LOCK_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0]         GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0]         HOLD_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [NUM_STAGES-1:0] ALL_ON    = '1;

  rs_state_e             st_q, st_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_d;
  logic                  ready_d;
  logic [7:0]            loss_d;
  logic                  locked_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  assign state = st_q;

  // State, shared counter and registered reset outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      rst_out       <= ALL_ON;
      ready         <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      rst_out       <= rst_d;
      ready         <= ready_d;
      lock_loss_cnt <= loss_d;
    end
  end

  // Next state: lock loss beats soft reset beats normal sequencing. The
  // released stages form a run of zeros at the bottom of rst_out, so a left
  // shift releases the next stage and keeps clearing strictly ascending.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    rst_d   = rst_out;
    ready_d = ready;
    loss_d  = lock_loss_cnt;
    if (st_q != ST_WAIT_LOCK && !locked_s) begin
      st_d    = ST_WAIT_LOCK;
      cnt_d   = '0;
      rst_d   = ALL_ON;
      ready_d = 1'b0;
      if (lock_loss_cnt != 8'hFF) begin
        loss_d = lock_loss_cnt + 8'd1;
      end
    end else if ((st_q == ST_RELEASE || st_q == ST_RUN) && soft_rst_req) begin
      st_d    = ST_SOFT_HOLD;
      cnt_d   = HOLD_LAST;
      rst_d   = ALL_ON;
      ready_d = 1'b0;
    end else begin
      unique case (st_q)
        ST_WAIT_LOCK: begin
          rst_d   = ALL_ON;
          ready_d = 1'b0;
          if (!locked_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            st_d  = ST_RELEASE;
            cnt_d = GAP_LAST;
            rst_d = ALL_ON << 1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (rst_out != '0) begin
            rst_d = rst_out << 1;
            cnt_d = GAP_LAST;
          end else begin
            st_d    = ST_RUN;
            ready_d = 1'b1;
          end
        end
        ST_RUN: begin
        end
        ST_SOFT_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            st_d  = ST_RELEASE;
            cnt_d = GAP_LAST;
            rst_d = ALL_ON << 1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized scoreboard bench for reset_sequencer
module tb_reset_sequencer;

  localparam int N   = 3;
  localparam int LS  = 8;
  localparam int GAP = 4;
  localparam int SH  = 6;
  localparam logic [N-1:0] ONES = '1;
  localparam int MQ = 0;  // qualifying lock
  localparam int MS = 1;  // sequencing / running
  localparam int MH = 2;  // soft hold

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         locked = 1'b0;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [1:0]   state;
  logic [7:0]   lock_loss_cnt;

  reset_sequencer #(
    .NUM_STAGES (N),
    .LOCK_STABLE(LS),
    .STAGE_GAP  (GAP),
    .SOFT_HOLD  (SH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .rst_out      (rst_out),
    .ready        (ready),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, m_edge);
    end
  endtask

  typedef struct {
    int edge_n;
    int ro;
    int rdy;
    int st;
    int loss;
  } ev_t;

  ev_t exp_q[$];

  // Reference model: timestamps of the last release start / soft request.
  int   m_edge = -1;
  int   m_mode = MQ;
  int   m_run = 0;
  int   m_t0 = 0;
  int   m_ks = 0;
  int   m_loss = 0;
  bit   m_lk[$];
  ev_t  m_last;
  bit   mon_en = 1'b0;

  task automatic model_edge(input bit lk, input bit sf);
    bit  ls;
    ev_t ev;
    int  el;
    ls = m_lk.pop_front();
    m_lk.push_back(lk);
    if (m_mode == MQ) begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LS) begin
        m_mode = MS;
        m_t0   = m_edge;
      end
    end else if (!ls) begin
      m_mode = MQ;
      m_run  = 0;
      if (m_loss < 255) m_loss++;
    end else if (m_mode == MS && sf) begin
      m_mode = MH;
      m_ks   = m_edge;
    end else if (m_mode == MH && m_edge - m_ks == SH) begin
      m_mode = MS;
      m_t0   = m_edge;
    end
    ev.edge_n = m_edge;
    ev.loss   = m_loss;
    if (m_mode == MS) begin
      el = m_edge - m_t0;
      ev.ro = 0;
      for (int i = 0; i < N; i++) begin
        if (el < i * GAP) ev.ro = ev.ro | (1 << i);
      end
      ev.rdy = (el >= N * GAP) ? 1 : 0;
      ev.st  = ev.rdy ? 2 : 1;
    end else begin
      ev.ro  = (1 << N) - 1;
      ev.rdy = 0;
      ev.st  = (m_mode == MQ) ? 0 : 3;
    end
    if (ev.ro != m_last.ro || ev.rdy != m_last.rdy || ev.st != m_last.st || ev.loss != m_last.loss)
      exp_q.push_back(ev);
    m_last = ev;
  endtask

  task automatic step(input bit lk, input bit sf);
    locked       = lk;
    soft_rst_req = sf;
    @(posedge clk);
    m_edge++;
    model_edge(lk, sf);
    @(negedge clk);
  endtask

  // Monitor: every change of the DUT outputs must match the next queued event.
  initial begin : monitor
    logic [N-1:0] p_ro;
    logic         p_rdy;
    logic [1:0]   p_st;
    logic [7:0]   p_loss;
    ev_t          ev;
    p_ro = ONES;
    p_rdy = 1'b0;
    p_st = 2'd0;
    p_loss = 8'd0;
    forever begin
      @(negedge clk);
      if (mon_en && ({rst_out, ready, state, lock_loss_cnt} != {p_ro, p_rdy, p_st, p_loss})) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output_change", int'({rst_out, ready, state, lock_loss_cnt}),
              int'({p_ro, p_rdy, p_st, p_loss}));
        end else begin
          ev = exp_q.pop_front();
          chk("event_edge", m_edge, ev.edge_n);
          chk("rst_out", int'(rst_out), ev.ro);
          chk("ready", int'(ready), ev.rdy);
          chk("state", int'(state), ev.st);
          chk("lock_loss_cnt", int'(lock_loss_cnt), ev.loss);
        end
        p_ro   = rst_out;
        p_rdy  = ready;
        p_st   = state;
        p_loss = lock_loss_cnt;
      end
    end
  end

  initial begin : driver
    int n;
    int guard;
    m_lk.push_back(1'b0);
    m_lk.push_back(1'b0);
    m_last.edge_n = -1;
    m_last.ro     = (1 << N) - 1;
    m_last.rdy    = 0;
    m_last.st     = 0;
    m_last.loss   = 0;

    // Power-up: reset held with lock already present.
    rst    = 1'b1;
    locked = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_rst_out", int'(rst_out), int'(ONES));
    chk("reset_ready", int'(ready), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_loss", int'(lock_loss_cnt), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (30) step(1'b1, 1'b0);

    // Soft reset from RUN.
    step(1'b1, 1'b1);
    repeat (25) step(1'b1, 1'b0);

    // Lock loss in RUN, then full re-sequence.
    repeat (3) step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);

    // One-cycle glitch once qualification has counted to 5.
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);

    // Soft reset while rst_out = 100 in RELEASE.
    repeat (3) step(1'b0, 1'b0);
    guard = 0;
    while (!(m_mode == MS && m_edge - m_t0 == 5) && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b0);

    // Soft reset requests during WAIT_LOCK are ignored.
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b0);

    // Soft request on the same edge that lock loss is seen.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (30) step(1'b1, 1'b0);

    // Random lock / soft-request episodes.
    for (int ep = 0; ep < 150; ep++) begin
      n = $urandom_range(0, 40);
      for (int c = 0; c < n; c++) step(1'b1, ($urandom_range(0, 15) == 0));
      n = $urandom_range(1, 3);
      for (int c = 0; c < n; c++) step(1'b0, ($urandom_range(0, 7) == 0));
    end

    // 300 lock losses drive the counter into saturation.
    for (int k = 0; k < 300; k++) begin
      repeat (14) step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
    end
    repeat (30) step(1'b1, 1'b0);
    chk("lock_loss_saturated", int'(lock_loss_cnt), 255);

    @(negedge clk);
    mon_en = 1'b0;
    chk("unconsumed_events", exp_q.size(), 0);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", int'(rst_out), int'(ONES));
    chk("async_ready", int'(ready), 0);
    chk("async_state", int'(state), 0);
    chk("async_loss", int'(lock_loss_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
